sv32_ptw_walk_scheduler: RTL and testbench
==========================================

Name: sv32_ptw_walk_scheduler

Overview:
- Sequences the Sv32 hardware page-table walker and shares it between the ITLB and DTLB miss paths.
- Accepts one miss request at a time and arbitrates round-robin between the two paths.
- Presents each accepted miss to the walker as a single-cycle shared-TLB-miss strobe, with vaddr, ASID, instr and store attributes held stable for the whole walk.
- Routes the walk outcome (refill, page fault, access fault) back to the requester that owns the walk; handles flush and walk timeout.

Parameters:
- VLEN, 32, virtual address width.
- ASID_WIDTH, 1, ASID width.
- TIMEOUT_CYCLES, 512, cycles a walk may stay active before it is abandoned; 0 disables the timeout.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- flush_i  in  1  cancels pending and in-flight walks.
- asid_i  in  ASID_WIDTH  current ASID, sampled at accept.
- itlb_req_i  in  1  ITLB miss request, held until gnt.
- itlb_vaddr_i  in  VLEN  ITLB miss vaddr.
- itlb_gnt_o  out  1  ITLB request accepted.
- itlb_done_o  out  1  ITLB walk finished (pulse).
- itlb_pf_o  out  1  page fault, qualified by done.
- itlb_af_o  out  1  access fault, qualified by done.
- dtlb_req_i  in  1  DTLB miss request, held until gnt.
- dtlb_vaddr_i  in  VLEN  DTLB miss vaddr.
- dtlb_is_store_i  in  1  DTLB miss is a store.
- dtlb_gnt_o, dtlb_done_o, dtlb_pf_o, dtlb_af_o  out  1 each  as for ITLB.
- walk_valid_o  out  1  miss strobe to walker (access=1, hit=0).
- walk_vaddr_o  out  VLEN  registered walk vaddr.
- walk_asid_o  out  ASID_WIDTH  registered walk ASID.
- walk_is_instr_o  out  1  walk is for ITLB.
- walk_is_store_o  out  1  walk is for a store.
- ptw_active_i  in  1  walker busy.
- ptw_update_valid_i  in  1  walker refill pulse.
- ptw_error_i  in  1  walker page-fault pulse.
- ptw_access_exception_i  in  1  walker PMP-fault pulse.
- busy_o  out  1  scheduler not IDLE.
- timeout_o  out  1  walk abandoned (pulse).

Behaviour:
- Reset: state IDLE, rr_q=0 (ITLB preferred), all registers and outputs 0.
- States: IDLE, ISSUE, WALK, DRAIN.
- IDLE, accepting a request:
  - Acceptance requires !flush_i and at least one request.
  - Winner: the only requester; if both request, ITLB when rr_q=0, else DTLB.
  - Combinationally assert the winner's gnt_o in the same cycle.
  - Register vaddr, asid_i, is_instr=(winner==ITLB), is_store=(winner==DTLB && dtlb_is_store_i).
  - Set rr_q = (winner==ITLB); clear result flags. Next state ISSUE.
- ISSUE:
  - walk_valid_o=1 for exactly this cycle. Next state WALK; timeout counter cleared.
  - If flush_i: suppress walk_valid_o and go to IDLE; no done is issued.
- WALK:
  - Sticky-latch ok/pf/af from ptw_update_valid_i, ptw_error_i, ptw_access_exception_i.
  - Pulses arriving in the completion cycle are included in the result.
  - Completion is the first WALK cycle with ptw_active_i=0. The owner's done_o pulses for 1 cycle with:
    - pf_o = pf_latched;
    - af_o = af_latched | (no ok/pf/af seen).
  - Next state IDLE. Consequence: a new request is accepted no earlier than the cycle after done.
  - Counter increments each WALK cycle. If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1 with ptw_active_i=1:
    - pulse timeout_o;
    - owner done_o=1 with af_o=1;
    - go to DRAIN.
  - flush_i in WALK: go to DRAIN; no done is issued. If completion and flush coincide, flush wins.
- DRAIN: wait for ptw_active_i=0, then IDLE. All walker result pulses are ignored; no done is issued.
- walk_* outputs remain stable from ISSUE until the cycle the state leaves WALK/DRAIN.
- Requesters must keep req, vaddr and is_store stable until gnt. A deasserted req without gnt is legal; no state is held for it.
- pf_o/af_o are 0 whenever done_o=0. At most one done_o is asserted per cycle.
- busy_o = (state != IDLE).
- Counter width is clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.

Test Plan:
- ITLB-only miss at vaddr 0x8040_1000; walker active 5 cycles with ptw_update_valid_i → itlb_gnt_o in cycle 0; walk_valid_o in cycle 1 only, walk_is_instr_o=1; itlb_done_o=1, pf=0, af=0 in the first cycle active=0; dtlb outputs stay 0.
- Both requesting from reset, repeated 4 walks → grant order I, D, I, D; the DTLB store walk shows walk_is_store_o=1.
- DTLB walk with ptw_error_i pulse, then active=0 in the same cycle → dtlb_done_o=1, pf=1, af=0; itlb_done_o never asserts.
- flush_i in ISSUE → walk_valid_o=0, state IDLE next cycle, no done. flush_i mid-WALK with active held 3 more cycles → no done, busy_o=1 until active=0.
- TIMEOUT_CYCLES=8, walker stuck active → timeout_o and owner done with af=1 in the 8th WALK cycle; busy_o stays 1 until active drops; a later ptw_update_valid_i is ignored.
- Asynchronous rst_i asserted mid-WALK → all outputs 0 immediately; after release ITLB is preferred on a simultaneous request.

Source files
------------

// File: rtl/sv32_ptw_walk_scheduler.sv
// -----------------------------------------------------------------------------
// sv32_ptw_walk_scheduler
//
// Shares one Sv32 page-table walker between the ITLB and DTLB miss paths.
// One miss is in service at a time. When both paths request together, the
// winner alternates (round-robin), starting with the ITLB. An accepted miss
// reaches the walker as a one-cycle strobe. Its attributes are then held
// stable until the walk is over. The walk result goes back only to the path
// that owns the walk.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   flush_i                 cancel pending/in-flight walk (no done issued)
//   asid_i                  current ASID, captured when a miss is accepted
//   itlb_req_i/_vaddr_i     ITLB miss request (held until gnt) and address
//   itlb_gnt_o              ITLB request accepted (same cycle as request)
//   itlb_done_o/_pf_o/_af_o ITLB walk finished, page fault, access fault
//   dtlb_req_i/_vaddr_i     DTLB miss request and address
//   dtlb_is_store_i         DTLB miss came from a store
//   dtlb_gnt_o/_done_o/...  as for ITLB
//   walk_valid_o            one-cycle miss strobe to the walker
//   walk_vaddr_o/_asid_o    registered walk attributes
//   walk_is_instr_o         walk belongs to the ITLB
//   walk_is_store_o         walk is for a DTLB store
//   ptw_active_i            walker busy
//   ptw_update_valid_i      walker refill pulse
//   ptw_error_i             walker page-fault pulse
//   ptw_access_exception_i  walker PMP access-fault pulse
//   busy_o                  scheduler not idle
//   timeout_o               walk abandoned after TIMEOUT_CYCLES (pulse)
// -----------------------------------------------------------------------------
module sv32_ptw_walk_scheduler #(
    parameter int unsigned VLEN           = 32,
    parameter int unsigned ASID_WIDTH     = 1,
    parameter int unsigned TIMEOUT_CYCLES = 512
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic [ASID_WIDTH-1:0] asid_i,

    input  logic                  itlb_req_i,
    input  logic [VLEN-1:0]       itlb_vaddr_i,
    output logic                  itlb_gnt_o,
    output logic                  itlb_done_o,
    output logic                  itlb_pf_o,
    output logic                  itlb_af_o,

    input  logic                  dtlb_req_i,
    input  logic [VLEN-1:0]       dtlb_vaddr_i,
    input  logic                  dtlb_is_store_i,
    output logic                  dtlb_gnt_o,
    output logic                  dtlb_done_o,
    output logic                  dtlb_pf_o,
    output logic                  dtlb_af_o,

    output logic                  walk_valid_o,
    output logic [VLEN-1:0]       walk_vaddr_o,
    output logic [ASID_WIDTH-1:0] walk_asid_o,
    output logic                  walk_is_instr_o,
    output logic                  walk_is_store_o,

    input  logic                  ptw_active_i,
    input  logic                  ptw_update_valid_i,
    input  logic                  ptw_error_i,
    input  logic                  ptw_access_exception_i,

    output logic                  busy_o,
    output logic                  timeout_o
);

    // The counter must hold TIMEOUT_CYCLES. It is kept at least one bit wide
    // so that the timeout-disabled build still elaborates.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 32'd0) ? $clog2(TIMEOUT_CYCLES + 32'd1) : 1;
    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 32'd0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_EN ? (TIMEOUT_CYCLES - 32'd1) : 32'd0);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WALK  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic                  rr_q, rr_d;
    logic [VLEN-1:0]       vaddr_q, vaddr_d;
    logic [ASID_WIDTH-1:0] asid_q, asid_d;
    logic                  is_instr_q, is_instr_d;
    logic                  is_store_q, is_store_d;
    logic                  ok_q, ok_d;
    logic                  pf_q, pf_d;
    logic                  af_q, af_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  gnt_i_s;
    logic                  gnt_d_s;
    logic                  walk_valid_s;
    logic                  done_s;
    logic                  done_pf_s;
    logic                  done_af_s;
    logic                  timeout_s;
    logic                  ok_s;
    logic                  pf_s;
    logic                  af_s;

    // Next-state, arbitration and walk-result logic.
    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        vaddr_d      = vaddr_q;
        asid_d       = asid_q;
        is_instr_d   = is_instr_q;
        is_store_d   = is_store_q;
        ok_d         = ok_q;
        pf_d         = pf_q;
        af_d         = af_q;
        cnt_d        = cnt_q;
        gnt_i_s      = 1'b0;
        gnt_d_s      = 1'b0;
        walk_valid_s = 1'b0;
        done_s       = 1'b0;
        done_pf_s    = 1'b0;
        done_af_s    = 1'b0;
        timeout_s    = 1'b0;
        // Walker pulses in the current cycle count toward the result, so the
        // completion cycle sees them as well.
        ok_s         = ok_q | ptw_update_valid_i;
        pf_s         = pf_q | ptw_error_i;
        af_s         = af_q | ptw_access_exception_i;

        case (state_q)
            S_IDLE: begin
                if (!flush_i && (itlb_req_i || dtlb_req_i)) begin
                    // ITLB wins when it is the only requester, or when both
                    // request and it is the ITLB's turn (rr_q == 0).
                    if (itlb_req_i && (!dtlb_req_i || !rr_q)) begin
                        gnt_i_s = 1'b1;
                    end else begin
                        gnt_d_s = 1'b1;
                    end
                    vaddr_d    = gnt_i_s ? itlb_vaddr_i : dtlb_vaddr_i;
                    asid_d     = asid_i;
                    is_instr_d = gnt_i_s;
                    is_store_d = gnt_d_s & dtlb_is_store_i;
                    rr_d       = gnt_i_s;
                    ok_d       = 1'b0;
                    pf_d       = 1'b0;
                    af_d       = 1'b0;
                    state_d    = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_ISSUE: begin
                cnt_d = {CNT_W{1'b0}};
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    walk_valid_s = 1'b1;
                    state_d      = S_WALK;
                end
            end

            S_WALK: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
                if (flush_i) begin
                    // A flush beats a completion in the same cycle.
                    state_d = S_DRAIN;
                end else if (!ptw_active_i) begin
                    done_s    = 1'b1;
                    done_pf_s = pf_s;
                    // A walk that ends without any outcome is reported as an
                    // access fault, so the requester never sees a silent done.
                    done_af_s = af_s | ~(ok_s | pf_s | af_s);
                    state_d   = S_IDLE;
                end else if (TIMEOUT_EN && (cnt_q == TO_LAST)) begin
                    timeout_s = 1'b1;
                    done_s    = 1'b1;
                    done_af_s = 1'b1;
                    state_d   = S_DRAIN;
                end else begin
                    ok_d = ok_s;
                    pf_d = pf_s;
                    af_d = af_s;
                end
            end

            S_DRAIN: begin
                if (!ptw_active_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and walk-attribute registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            rr_q       <= 1'b0;
            vaddr_q    <= {VLEN{1'b0}};
            asid_q     <= {ASID_WIDTH{1'b0}};
            is_instr_q <= 1'b0;
            is_store_q <= 1'b0;
            ok_q       <= 1'b0;
            pf_q       <= 1'b0;
            af_q       <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            vaddr_q    <= vaddr_d;
            asid_q     <= asid_d;
            is_instr_q <= is_instr_d;
            is_store_q <= is_store_d;
            ok_q       <= ok_d;
            pf_q       <= pf_d;
            af_q       <= af_d;
            cnt_q      <= cnt_d;
        end
    end

    // Grants are combinational off the live requests. They are masked while
    // reset is held, so every output reads 0 during reset.
    assign itlb_gnt_o      = gnt_i_s & ~rst_i;
    assign dtlb_gnt_o      = gnt_d_s & ~rst_i;

    // Only the owner of the walk sees done. Fault flags are qualified by done.
    assign itlb_done_o     = done_s & is_instr_q;
    assign itlb_pf_o       = done_s & is_instr_q & done_pf_s;
    assign itlb_af_o       = done_s & is_instr_q & done_af_s;
    assign dtlb_done_o     = done_s & ~is_instr_q;
    assign dtlb_pf_o       = done_s & ~is_instr_q & done_pf_s;
    assign dtlb_af_o       = done_s & ~is_instr_q & done_af_s;

    assign walk_valid_o    = walk_valid_s;
    assign walk_vaddr_o    = vaddr_q;
    assign walk_asid_o     = asid_q;
    assign walk_is_instr_o = is_instr_q;
    assign walk_is_store_o = is_store_q;

    assign busy_o          = (state_q != S_IDLE);
    assign timeout_o       = timeout_s;

endmodule

// File: tb/tb_sv32_ptw_walk_scheduler.sv
module tb_sv32_ptw_walk_scheduler;

    localparam int TO = 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic [0:0]  asid_i = 1'b0;
    logic        itlb_req_i = 1'b0;
    logic [31:0] itlb_vaddr_i = 32'h0;
    logic        itlb_gnt_o, itlb_done_o, itlb_pf_o, itlb_af_o;
    logic        dtlb_req_i = 1'b0;
    logic [31:0] dtlb_vaddr_i = 32'h0;
    logic        dtlb_is_store_i = 1'b0;
    logic        dtlb_gnt_o, dtlb_done_o, dtlb_pf_o, dtlb_af_o;
    logic        walk_valid_o;
    logic [31:0] walk_vaddr_o;
    logic [0:0]  walk_asid_o;
    logic        walk_is_instr_o, walk_is_store_o;
    logic        ptw_active_i = 1'b0;
    logic        ptw_update_valid_i = 1'b0;
    logic        ptw_error_i = 1'b0;
    logic        ptw_access_exception_i = 1'b0;
    logic        busy_o, timeout_o;

    int n_vec = 0;
    int n_err = 0;

    sv32_ptw_walk_scheduler #(
        .VLEN(32), .ASID_WIDTH(1), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .asid_i(asid_i),
        .itlb_req_i(itlb_req_i), .itlb_vaddr_i(itlb_vaddr_i),
        .itlb_gnt_o(itlb_gnt_o), .itlb_done_o(itlb_done_o),
        .itlb_pf_o(itlb_pf_o), .itlb_af_o(itlb_af_o),
        .dtlb_req_i(dtlb_req_i), .dtlb_vaddr_i(dtlb_vaddr_i),
        .dtlb_is_store_i(dtlb_is_store_i),
        .dtlb_gnt_o(dtlb_gnt_o), .dtlb_done_o(dtlb_done_o),
        .dtlb_pf_o(dtlb_pf_o), .dtlb_af_o(dtlb_af_o),
        .walk_valid_o(walk_valid_o), .walk_vaddr_o(walk_vaddr_o),
        .walk_asid_o(walk_asid_o), .walk_is_instr_o(walk_is_instr_o),
        .walk_is_store_o(walk_is_store_o),
        .ptw_active_i(ptw_active_i), .ptw_update_valid_i(ptw_update_valid_i),
        .ptw_error_i(ptw_error_i), .ptw_access_exception_i(ptw_access_exception_i),
        .busy_o(busy_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model, checked every falling edge ----------
    localparam int P_IDLE = 0, P_ISSUE = 1, P_WALK = 2, P_DRAIN = 3;
    int          m_phase = P_IDLE;
    bit          m_turn_d = 1'b0;     // 1: DTLB wins a tie next time
    logic [31:0] m_vaddr = 32'h0;
    logic [0:0]  m_asid = 1'b0;
    bit          m_instr = 1'b0, m_store = 1'b0;
    bit          m_ok = 1'b0, m_pf = 1'b0, m_af = 1'b0;
    int          m_age = 0;           // completed walk cycles

    initial begin
        forever begin
            bit e_gi, e_gd, e_wv, e_fin, e_pf, e_af, e_to, e_busy, pick_i;
            bit g_ok, g_pf, g_af;
            int n_phase;
            @(negedge clk_i);
            e_gi = 0; e_gd = 0; e_wv = 0; e_fin = 0; e_pf = 0; e_af = 0; e_to = 0;
            e_busy = 0; n_phase = m_phase;
            if (!rst_i) begin
                e_busy = (m_phase != P_IDLE);
                g_ok = m_ok | ptw_update_valid_i;
                g_pf = m_pf | ptw_error_i;
                g_af = m_af | ptw_access_exception_i;
                if (m_phase == P_ISSUE) begin
                    e_wv = !flush_i;
                end
                if (m_phase == P_WALK && !flush_i) begin
                    if (!ptw_active_i) begin
                        e_fin = 1; e_pf = g_pf; e_af = g_af || !(g_ok || g_pf || g_af);
                    end else if (m_age + 1 == TO) begin
                        e_fin = 1; e_af = 1; e_to = 1;
                    end
                end
                if (m_phase == P_IDLE && !flush_i && (itlb_req_i || dtlb_req_i)) begin
                    pick_i = itlb_req_i && !(dtlb_req_i && m_turn_d);
                    e_gi = pick_i; e_gd = !pick_i;
                end
            end
            chk("m_itlb_gnt", itlb_gnt_o, e_gi);
            chk("m_dtlb_gnt", dtlb_gnt_o, e_gd);
            chk("m_walk_valid", walk_valid_o, e_wv);
            chk("m_itlb_done", itlb_done_o, e_fin && m_instr && !rst_i);
            chk("m_dtlb_done", dtlb_done_o, e_fin && !m_instr && !rst_i);
            chk("m_itlb_pf", itlb_pf_o, e_fin && m_instr && e_pf);
            chk("m_itlb_af", itlb_af_o, e_fin && m_instr && e_af);
            chk("m_dtlb_pf", dtlb_pf_o, e_fin && !m_instr && e_pf);
            chk("m_dtlb_af", dtlb_af_o, e_fin && !m_instr && e_af);
            chk("m_timeout", timeout_o, e_to);
            chk("m_busy", busy_o, e_busy);
            chk("m_walk_vaddr", walk_vaddr_o, rst_i ? 32'h0 : m_vaddr);
            chk("m_walk_asid", walk_asid_o, rst_i ? 1'b0 : m_asid);
            chk("m_walk_instr", walk_is_instr_o, rst_i ? 1'b0 : m_instr);
            chk("m_walk_store", walk_is_store_o, rst_i ? 1'b0 : m_store);
            // advance the model to what the next rising edge produces
            if (rst_i) begin
                m_phase = P_IDLE; m_turn_d = 0; m_vaddr = 32'h0; m_asid = 1'b0;
                m_instr = 0; m_store = 0; m_ok = 0; m_pf = 0; m_af = 0; m_age = 0;
            end else begin
                case (m_phase)
                    P_IDLE: if (e_gi || e_gd) begin
                        n_phase = P_ISSUE; m_vaddr = e_gi ? itlb_vaddr_i : dtlb_vaddr_i;
                        m_asid = asid_i; m_instr = e_gi; m_store = e_gd && dtlb_is_store_i;
                        m_turn_d = e_gi; m_ok = 0; m_pf = 0; m_af = 0;
                    end
                    P_ISSUE: begin n_phase = flush_i ? P_IDLE : P_WALK; m_age = 0; end
                    P_WALK: begin
                        if (flush_i) n_phase = P_DRAIN;
                        else if (!ptw_active_i) n_phase = P_IDLE;
                        else if (e_to) n_phase = P_DRAIN;
                        else begin m_ok = g_ok; m_pf = g_pf; m_af = g_af; end
                        m_age = m_age + 1;
                    end
                    P_DRAIN: if (!ptw_active_i) n_phase = P_IDLE;
                    default: n_phase = P_IDLE;
                endcase
                m_phase = n_phase;
            end
        end
    end

    // ---------------- directed stimulus with literal expectations ------------
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // Called in an idle cycle; returns in the issue cycle.
    task automatic request(input bit ireq, input bit dreq, input logic [31:0] iva,
                           input logic [31:0] dva, input bit st, input bit exp_i,
                           input bit flush_issue);
        itlb_req_i = ireq; dtlb_req_i = dreq; itlb_vaddr_i = iva;
        dtlb_vaddr_i = dva; dtlb_is_store_i = st;
        #1;
        chk("gnt_itlb", itlb_gnt_o, exp_i);
        chk("gnt_dtlb", dtlb_gnt_o, !exp_i);
        cyc();
        itlb_req_i = 0; dtlb_req_i = 0; flush_i = flush_issue;
        #1;
        chk("issue_valid", walk_valid_o, !flush_issue);
        chk("issue_instr", walk_is_instr_o, exp_i);
        chk("issue_vaddr", walk_vaddr_o, exp_i ? iva : dva);
        chk("issue_store", walk_is_store_o, !exp_i && st);
        chk("issue_busy", busy_o, 1'b1);
    endtask

    // Called in the issue cycle; returns in the idle cycle after done.
    task automatic run_walker(input int n, input bit upd_last, input bit acc_first,
                              input bit err_at_done, input bit exp_i,
                              input bit exp_pf, input bit exp_af);
        for (int i = 0; i < n; i++) begin
            cyc();
            ptw_active_i = 1; ptw_update_valid_i = upd_last && (i == n - 1);
            ptw_access_exception_i = acc_first && (i == 0);
            #1;
            chk("walk_no_done", {itlb_done_o, dtlb_done_o}, 2'b00);
            chk("walk_strobe_off", walk_valid_o, 1'b0);
        end
        cyc();
        ptw_active_i = 0; ptw_update_valid_i = 0; ptw_access_exception_i = 0;
        ptw_error_i = err_at_done;
        #1;
        chk("done_itlb", itlb_done_o, exp_i);
        chk("done_dtlb", dtlb_done_o, !exp_i);
        chk("done_pf", exp_i ? itlb_pf_o : dtlb_pf_o, exp_pf);
        chk("done_af", exp_i ? itlb_af_o : dtlb_af_o, exp_af);
        cyc();
        ptw_error_i = 0;
        #1;
        chk("after_done_busy", busy_o, 1'b0);
        chk("after_done_none", {itlb_done_o, dtlb_done_o}, 2'b00);
    endtask

    bit exp_order[4] = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        // reset
        cyc(); cyc();
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_vaddr", walk_vaddr_o, 32'h0);
        chk("rst_valid", walk_valid_o, 1'b0);
        rst_i = 0;
        cyc();

        // both requesting from reset: I, D, I, D; D walks are stores
        for (int k = 0; k < 4; k++) begin
            request(1, 1, 32'h0001_0000 + 32'(k << 12), 32'h4000_0000 + 32'(k << 12),
                    1, exp_order[k], 0);
            run_walker(2, k < 2, k == 2, 0, exp_order[k], 0, k >= 2);
        end

        // ITLB-only miss, 5 active cycles with a refill
        asid_i = 1'b1;
        request(1, 0, 32'h8040_1000, 32'h0, 0, 1, 0);
        chk("t1_asid", walk_asid_o, 1'b1);
        asid_i = 1'b0;
        run_walker(5, 1, 0, 0, 1, 0, 0);

        // DTLB walk, page fault in the completion cycle
        request(0, 1, 32'h0, 32'hC000_2000, 0, 0, 0);
        run_walker(3, 0, 0, 1, 0, 1, 0);

        // flush in ISSUE
        request(1, 0, 32'h1234_5000, 32'h0, 0, 1, 1);
        cyc();
        flush_i = 0;
        #1;
        chk("fl_issue_idle", busy_o, 1'b0);
        chk("fl_issue_nodone", {itlb_done_o, dtlb_done_o}, 2'b00);

        // flush mid-WALK, walker stays active 3 more cycles
        request(0, 1, 32'h0, 32'h2222_3000, 1, 0, 0);
        cyc(); ptw_active_i = 1;
        cyc(); flush_i = 1;
        #1;
        chk("fl_walk_nodone", {itlb_done_o, dtlb_done_o}, 2'b00);
        for (int i = 0; i < 3; i++) begin
            cyc(); flush_i = 0; ptw_update_valid_i = (i == 1);
            #1;
            chk("fl_drain_busy", busy_o, 1'b1);
            chk("fl_drain_nodone", {itlb_done_o, dtlb_done_o}, 2'b00);
        end
        cyc(); ptw_active_i = 0; ptw_update_valid_i = 0;
        #1;
        chk("fl_drain_last_busy", busy_o, 1'b1);
        cyc();
        #1;
        chk("fl_drain_idle", busy_o, 1'b0);

        // timeout: walker stuck active
        request(1, 0, 32'h5555_6000, 32'h0, 0, 1, 0);
        for (int k = 1; k <= TO; k++) begin
            cyc(); ptw_active_i = 1;
            #1;
            chk("to_pulse", timeout_o, k == TO);
            chk("to_done", itlb_done_o, k == TO);
            chk("to_af", itlb_af_o, k == TO);
        end
        for (int j = 0; j < 2; j++) begin
            cyc(); ptw_update_valid_i = (j == 0);
            #1;
            chk("to_drain_busy", busy_o, 1'b1);
            chk("to_drain_nodone", {itlb_done_o, dtlb_done_o, timeout_o}, 3'b000);
        end
        cyc(); ptw_active_i = 0; ptw_update_valid_i = 0;
        #1;
        chk("to_drain_last", busy_o, 1'b1);
        cyc();
        #1;
        chk("to_idle", busy_o, 1'b0);

        // asynchronous reset mid-WALK after an ITLB win
        request(1, 0, 32'h6666_7000, 32'h0, 0, 1, 0);
        cyc(); ptw_active_i = 1;
        cyc();
        #2;
        rst_i = 1;
        #1;
        chk("arst_busy", busy_o, 1'b0);
        chk("arst_vaddr", walk_vaddr_o, 32'h0);
        chk("arst_instr", walk_is_instr_o, 1'b0);
        chk("arst_done", {itlb_done_o, dtlb_done_o, timeout_o, walk_valid_o}, 4'b0000);
        cyc(); cyc();
        rst_i = 0; ptw_active_i = 0;
        cyc();
        request(1, 1, 32'h7777_8000, 32'h8888_9000, 0, 1, 0);
        run_walker(1, 1, 0, 0, 1, 0, 0);

        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
